adc_acq_sequencer: RTL and testbench

//  Single-clock controller that runs one ADC acquisition frame end to end:

---
 rtl/adc_acq_sequencer.sv | 158 +++++++++++++++
 tb/tb_adc_acq_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_acq_sequencer.sv
// adc_acq_sequencer: runs one ADC acquisition frame: settle, capture, optional FFT, optional readback.
// Latency: a command takes effect on the next clk edge; all strobes are Moore outputs decoded from state.
// Backpressure: none; it waits on rdy_w, fft_done and rdy_r, and a timeout bounds each wait.
//
// Ports:
//   clk, rst (async active-low)         clock and reset
//   cmd_*                               frame commands from the UART command decoder
//   rdy_w, rdy_r, fft_done              status from the ADC capture/RAM block
//   write_en/start_fft/read_en/r_restart
//                                       strobes to the capture block
//   adcr_length                         latched readback length
//   busy, done_pulse, err_timeout, state_o, frame_cnt
//                                       status and debug outputs
module adc_acq_sequencer #(
    parameter int NA_ADC      = 8,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 65535,
    parameter int LEN_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic             cmd_fft_en,
    input  logic             cmd_rd_en,
    input  logic             cmd_continuous,
    input  logic [LEN_W-1:0] cmd_rd_length,
    input  logic             rdy_w,
    input  logic             rdy_r,
    input  logic             fft_done,
    output logic             write_en,
    output logic             start_fft,
    output logic             read_en,
    output logic             r_restart,
    output logic [LEN_W-1:0] adcr_length,
    output logic             busy,
    output logic             done_pulse,
    output logic             err_timeout,
    output logic [2:0]       state_o,
    output logic [15:0]      frame_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_FFT     = 3'd3;
    localparam logic [2:0] S_RESTART = 3'd4;
    localparam logic [2:0] S_READOUT = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    // One timer serves both the settle count and the wait timeout.
    localparam int TMAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    // Reject capture depths that cannot exist.
    if (NA_ADC < 1 || NA_ADC > 30) begin : g_bad_na_adc
        $error("adc_acq_sequencer: NA_ADC out of range");
    end

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    timer_q;
    logic             fft_en_q, rd_en_q, cont_q;
    logic [LEN_W-1:0] len_q;
    logic             done_q, err_q;
    logic [15:0]      frame_cnt_q;

    logic timed, counting, enter_settle, enter_done, enter_err;

    assign timed    = (timer_q == TIMEOUT_LAST);
    assign counting = (state_q == S_SETTLE) || (state_q == S_CAPTURE) ||
                      (state_q == S_FFT)    || (state_q == S_READOUT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (cmd_start) state_d = S_SETTLE;
            end
            S_DONE: begin
                if (cmd_start || cont_q) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (timer_q == SETTLE_LAST) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (rdy_w) begin
                    if (fft_en_q)     state_d = S_FFT;
                    else if (rd_en_q) state_d = S_RESTART;
                    else              state_d = S_DONE;
                end else if (timed) begin
                    state_d = S_ERR;
                end
            end
            S_FFT: begin
                if (fft_done)   state_d = rd_en_q ? S_RESTART : S_DONE;
                else if (timed) state_d = S_ERR;
            end
            S_RESTART: state_d = S_READOUT;
            S_READOUT: begin
                if (rdy_r)      state_d = S_DONE;
                else if (timed) state_d = S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort beats every other transition, including a simultaneous start.
        if (cmd_abort) state_d = S_IDLE;
    end

    assign enter_settle = (state_d == S_SETTLE) && (state_q != S_SETTLE);
    assign enter_done   = (state_d == S_DONE)   && (state_q != S_DONE);
    assign enter_err    = (state_d == S_ERR)    && (state_q != S_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            fft_en_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            cont_q      <= 1'b0;
            len_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) timer_q <= '0;
            else if (counting)      timer_q <= timer_q + 1'b1;
            // Command fields are sampled once per frame, including continuous re-arms.
            if (enter_settle) begin
                fft_en_q <= cmd_fft_en;
                rd_en_q  <= cmd_rd_en;
                cont_q   <= cmd_continuous;
                len_q    <= cmd_rd_length;
                err_q    <= 1'b0;
            end else if (enter_err) begin
                err_q <= 1'b1;
            end
            // Registered so the pulse covers exactly the first DONE cycle.
            done_q <= enter_done;
            if (enter_done) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign write_en    = (state_q == S_CAPTURE);
    assign start_fft   = (state_q == S_FFT);
    assign r_restart   = (state_q == S_RESTART);
    assign read_en     = (state_q == S_READOUT);
    assign busy        = counting || (state_q == S_RESTART);
    assign done_pulse  = done_q;
    assign err_timeout = err_q;
    assign adcr_length = len_q;
    assign state_o     = state_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// tb_adc_acq_sequencer: directed test of adc_acq_sequencer.
// Latency: inputs driven 1ns after posedge; outputs sampled at the same point.
// Backpressure: n/a; the bench plays the role of the capture block.
module tb_adc_acq_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_start = 0, cmd_abort = 0, cmd_fft_en = 0, cmd_rd_en = 0, cmd_continuous = 0;
    logic [15:0] cmd_rd_length = 16'd0;
    logic        rdy_w = 0, rdy_r = 0, fft_done = 0;

    logic        write_en, start_fft, read_en, r_restart, busy, done_pulse, err_timeout;
    logic [15:0] adcr_length, frame_cnt;
    logic [2:0]  state_o;

    logic        write_en2, start_fft2, read_en2, r_restart2, busy2, done_pulse2, err_timeout2;
    logic [15:0] adcr_length2, frame_cnt2;
    logic [2:0]  state_o2;

    int n_vec = 0;
    int n_err = 0;
    int strobe_clash = 0;
    logic seen_fft = 0, seen_rd = 0, seen_rs = 0;

    always #5 clk = ~clk;

    adc_acq_sequencer dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cmd_fft_en(cmd_fft_en), .cmd_rd_en(cmd_rd_en), .cmd_continuous(cmd_continuous),
        .cmd_rd_length(cmd_rd_length), .rdy_w(rdy_w), .rdy_r(rdy_r), .fft_done(fft_done),
        .write_en(write_en), .start_fft(start_fft), .read_en(read_en), .r_restart(r_restart),
        .adcr_length(adcr_length), .busy(busy), .done_pulse(done_pulse),
        .err_timeout(err_timeout), .state_o(state_o), .frame_cnt(frame_cnt)
    );

    // Short-timeout instance, shares the command inputs.
    adc_acq_sequencer #(.TIMEOUT_CYC(100)) dut_to (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cmd_fft_en(cmd_fft_en), .cmd_rd_en(cmd_rd_en), .cmd_continuous(cmd_continuous),
        .cmd_rd_length(cmd_rd_length), .rdy_w(rdy_w), .rdy_r(rdy_r), .fft_done(fft_done),
        .write_en(write_en2), .start_fft(start_fft2), .read_en(read_en2), .r_restart(r_restart2),
        .adcr_length(adcr_length2), .busy(busy2), .done_pulse(done_pulse2),
        .err_timeout(err_timeout2), .state_o(state_o2), .frame_cnt(frame_cnt2)
    );

    always @(negedge clk) begin
        if (32'(write_en) + 32'(start_fft) + 32'(read_en) + 32'(r_restart) > 1) strobe_clash++;
        if (start_fft) seen_fft = 1'b1;
        if (read_en)   seen_rd  = 1'b1;
        if (r_restart) seen_rs  = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic wait_st(input logic [2:0] s);
        int n = 0;
        while (state_o !== s && n < 2000) begin
            tick();
            n++;
        end
        if (state_o !== s) chk("wait_state", 32'(state_o), 32'(s));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #12;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int cnt;
        // ---------------- reset state
        #12;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_strobes", {write_en, start_fft, read_en, r_restart, busy, done_pulse, err_timeout}, 0);
        chk("rst_len", 32'(adcr_length), 0);
        chk("rst_frames", 32'(frame_cnt), 0);
        rst = 1'b1;
        tick();

        // ---------------- full frame: FFT + readback, len 100
        cmd_fft_en = 1; cmd_rd_en = 1; cmd_rd_length = 16'd100;
        pulse_start();
        chk("f1_settle", 32'(state_o), 1);
        chk("f1_len", 32'(adcr_length), 100);
        chk("f1_busy", 32'(busy), 1);
        cnt = 0;
        while (state_o == 3'd1 && cnt < 100) begin cnt++; tick(); end
        chk("f1_settle_cyc", cnt, 16);
        chk("f1_capture", 32'(state_o), 2);
        chk("f1_wen", 32'(write_en), 1);
        fft_done = 1; tick(); fft_done = 0;
        chk("f1_fftdone_ignored", 32'(state_o), 2);
        repeat (254) tick();
        rdy_w = 1; tick(); rdy_w = 0;
        chk("f1_fft", 32'(state_o), 3);
        chk("f1_fft_strobes", {write_en, start_fft}, 32'b01);
        pulse_start();
        chk("f1_start_ignored", 32'(state_o), 3);
        repeat (298) tick();
        fft_done = 1; tick(); fft_done = 0;
        chk("f1_restart", 32'(state_o), 4);
        chk("f1_restart_strobes", {start_fft, r_restart, read_en}, 32'b010);
        tick();
        chk("f1_readout", 32'(state_o), 5);
        chk("f1_readout_strobes", {r_restart, read_en}, 32'b01);
        repeat (20) tick();
        rdy_r = 1; tick(); rdy_r = 0;
        chk("f1_done", 32'(state_o), 6);
        chk("f1_done_pulse", {done_pulse, busy, read_en}, 32'b100);
        chk("f1_frames", 32'(frame_cnt), 1);
        tick();
        chk("f1_done_hold", {29'd0, state_o}, 6);
        chk("f1_pulse_once", 32'(done_pulse), 0);

        // ---------------- capture only, rdy_w already high on CAPTURE entry
        cmd_fft_en = 0; cmd_rd_en = 0;
        seen_fft = 0; seen_rd = 0; seen_rs = 0;
        pulse_start();
        rdy_w = 1;
        wait_st(3'd2);
        tick();
        rdy_w = 0;
        chk("f2_done", 32'(state_o), 6);
        chk("f2_frames", 32'(frame_cnt), 2);
        chk("f2_no_other_strobes", {seen_fft, seen_rd, seen_rs}, 0);

        // ---------------- continuous: three frames, abort in the fourth FFT
        do_reset();
        cmd_fft_en = 1; cmd_rd_en = 0; cmd_continuous = 1; rdy_w = 1;
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            wait_st(3'd3);
            fft_done = 1; tick(); fft_done = 0;
            chk("cont_done", {done_pulse, 1'b0, state_o}, 32'b10110);
        end
        wait_st(3'd3);
        cmd_abort = 1; tick(); cmd_abort = 0;
        rdy_w = 0; cmd_continuous = 0;
        chk("abort_idle", 32'(state_o), 0);
        chk("abort_fft_low", 32'(start_fft), 0);
        chk("abort_frames", 32'(frame_cnt), 3);

        // ---------------- timeout on the short-timeout instance
        do_reset();
        cmd_fft_en = 0;
        pulse_start();
        cnt = 0;
        while (state_o2 != 3'd2 && cnt < 100) begin cnt++; tick(); end
        cnt = 0;
        while (state_o2 == 3'd2 && cnt < 300) begin cnt++; tick(); end
        chk("to_capture_cyc", cnt, 100);
        chk("to_err_state", 32'(state_o2), 7);
        chk("to_err_flags", {err_timeout2, busy2, write_en2}, 32'b100);
        tick();
        chk("to_err_sticky", 32'(err_timeout2), 1);
        pulse_start();
        chk("to_restart", {err_timeout2, 1'b0, state_o2}, 32'b00001);
        cmd_abort = 1; tick(); cmd_abort = 0;

        // ---------------- start and abort together from IDLE
        cmd_start = 1; cmd_abort = 1; tick(); cmd_start = 0; cmd_abort = 0;
        chk("start_abort_idle", {busy, 1'b0, state_o}, 0);

        // ---------------- async reset mid-readout
        cmd_rd_en = 1; cmd_rd_length = 16'd5; rdy_w = 1;
        pulse_start();
        wait_st(3'd5);
        rdy_w = 0;
        chk("rr_read_en", 32'(read_en), 1);
        chk("rr_len", 32'(adcr_length), 5);
        rst = 1'b0;
        #1;
        chk("rr_async_read_en", 32'(read_en), 0);
        chk("rr_async_state", 32'(state_o), 0);
        chk("rr_async_len", 32'(adcr_length), 0);
        chk("rr_no_done", 32'(done_pulse), 0);
        #10;
        rst = 1'b1;
        tick();

        chk("strobe_onehot", strobe_clash, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
